// File: rtl/fas_chk_pkg.sv
// ---------------------------------------------------------------------------
// fas_chk_pkg
// Shared definitions for the streaming result checker: default build
// constants and the run-state encoding used by fas_stream_checker.
// ---------------------------------------------------------------------------
package fas_chk_pkg;

    // Default build constants
    localparam int unsigned DefW         = 16;
    localparam int unsigned DefLanes     = 16;
    localparam int unsigned DefComplex   = 1;
    localparam int unsigned DefTol       = 3;
    localparam int unsigned DefNBeats    = 64;
    localparam int unsigned DefFailLimit = 48;
    localparam int unsigned DefAw        = 10;

    // Failing-lane counter is a fixed 8-bit saturating count
    localparam logic [7:0] FailCntMax = 8'hFF;

    // Run state; exactly one of busy/pass/fail is derived from it
    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StPass = 2'd1,
        StFail = 2'd2
    } state_e;

endpackage

// File: rtl/fas_tol_cmp.sv
// ---------------------------------------------------------------------------
// fas_tol_cmp
// Tolerance compare of one W-bit field. The difference is taken modulo 2^W,
// so values on either side of the wrap point are treated as neighbours.
//
// Ports
//   dut_i   : field value from the device under test
//   gold_i  : expected field value
//   match_o : 1 when |dut_i - gold_i| (modulo 2^W) <= TOL
// ---------------------------------------------------------------------------
module fas_tol_cmp
    import fas_chk_pkg::*;
#(
    parameter int unsigned W   = DefW,
    parameter int unsigned TOL = DefTol
) (
    input  logic [W-1:0] dut_i,
    input  logic [W-1:0] gold_i,
    output logic         match_o
);

    logic [W-1:0] diff_fwd;
    logic [W-1:0] diff_rev;

    // diff_fwd >= 2^W - TOL is the same as (gold - dut) mod 2^W <= TOL,
    // so both directions reduce to a small-magnitude test.
    always_comb begin
        diff_fwd = dut_i - gold_i;
        diff_rev = gold_i - dut_i;
        match_o  = (32'(diff_fwd) <= TOL) || (32'(diff_rev) <= TOL);
    end

endmodule

// File: rtl/fas_stream_checker.sv
// ---------------------------------------------------------------------------
// fas_stream_checker
// Compares a stream of DUT beats against a golden memory, lane by lane with
// a per-field tolerance, and tracks whether the run passes or fails.
//
// Pipeline
//   stage 0 : accept dut_data, issue gold_rd/gold_addr for the same index
//   stage 1 : gold_data arrives, compare, register err_* and update counts
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   dut_valid       : beat present on dut_data
//   dut_data        : LANES lanes of (COMPLEX+1) W-bit fields, real on top
//   gold_rd         : golden memory read strobe
//   gold_addr       : golden beat index
//   gold_data       : golden beat, one cycle after gold_rd
//   err_valid       : compare result strobe
//   err_lane_mask   : per-lane mismatch flags of the reported beat
//   err_beat        : index of the reported beat
//   fail_cnt        : saturating count of failing lanes
//   beat_cnt        : number of beats compared during the run
//   busy/pass/fail  : run state flags (one-hot)
//   overrun         : sticky, a beat arrived after the run terminated
// ---------------------------------------------------------------------------
module fas_stream_checker
    import fas_chk_pkg::*;
#(
    parameter int unsigned W          = DefW,
    parameter int unsigned LANES      = DefLanes,
    parameter int unsigned COMPLEX    = DefComplex,
    parameter int unsigned TOL        = DefTol,
    parameter int unsigned N_BEATS    = DefNBeats,
    parameter int unsigned FAIL_LIMIT = DefFailLimit,
    parameter int unsigned AW         = DefAw
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dut_valid,
    input  logic [LANES*(COMPLEX+1)*W-1:0]   dut_data,
    output logic                             gold_rd,
    output logic [AW-1:0]                    gold_addr,
    input  logic [LANES*(COMPLEX+1)*W-1:0]   gold_data,
    output logic                             err_valid,
    output logic [LANES-1:0]                 err_lane_mask,
    output logic [AW-1:0]                    err_beat,
    output logic [7:0]                       fail_cnt,
    output logic [AW-1:0]                    beat_cnt,
    output logic                             busy,
    output logic                             pass,
    output logic                             fail,
    output logic                             overrun
);

    localparam int unsigned FPL = COMPLEX + 1;  // fields per lane
    localparam int unsigned NF  = LANES * FPL;  // fields per beat
    localparam int unsigned LW  = NF * W;

    // State and registers
    state_e               state_q, state_d;
    logic [AW-1:0]        acc_q;                 // next accepted-beat index
    logic                 s1_valid_q;
    logic [LW-1:0]        s1_data_q;
    logic [AW-1:0]        s1_beat_q;
    logic                 err_valid_q;
    logic [LANES-1:0]     err_mask_q;
    logic [AW-1:0]        err_beat_q;
    logic [7:0]           fail_cnt_q, fail_cnt_d;
    // One extra bit so N_BEATS == 2^AW is still reachable
    logic [AW:0]          beat_cnt_q, beat_cnt_d;
    logic                 overrun_q;

    // Combinational stage-1 results
    logic                 accept;
    logic [NF-1:0]        field_match;
    logic [LANES-1:0]     lane_mask;
    logic [15:0]          lane_fails;
    logic [15:0]          fail_sum;
    logic [7:0]           fail_next;
    logic [AW:0]          beat_next;

    // Stage 0: a beat is taken only while the run is live
    always_comb begin
        accept    = dut_valid && !rst && (state_q == StRun);
        gold_rd   = accept;
        gold_addr = acc_q;
    end

    // Stage 1: one tolerance compare per field
    for (genvar f = 0; f < NF; f++) begin : g_field
        fas_tol_cmp #(
            .W   (W),
            .TOL (TOL)
        ) u_cmp (
            .dut_i   (s1_data_q[f*W +: W]),
            .gold_i  (gold_data[f*W +: W]),
            .match_o (field_match[f])
        );
    end

    // A lane fails if any of its fields fails
    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_mask[l] = ~(&field_match[l*FPL +: FPL]);
        end
    end

    always_comb begin
        lane_fails = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_fails = lane_fails + 16'(lane_mask[l]);
        end
        fail_sum  = 16'(fail_cnt_q) + lane_fails;
        fail_next = (fail_sum > 16'(FailCntMax)) ? FailCntMax : fail_sum[7:0];
        beat_next = beat_cnt_q + {{AW{1'b0}}, 1'b1};
    end

    // Counts and state move only for beats compared while still running;
    // beats draining after termination report but leave the verdict alone.
    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (s1_valid_q && (state_q == StRun)) begin
            fail_cnt_d = fail_next;
            beat_cnt_d = beat_next;
            // Limit check first so a simultaneous last beat still ends in FAIL
            if (32'(fail_next) >= FAIL_LIMIT) begin
                state_d = StFail;
            end else if (32'(beat_next) == N_BEATS) begin
                state_d = (fail_next == 8'd0) ? StPass : StFail;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_beat_q   <= '0;
            err_valid_q <= 1'b0;
            err_mask_q  <= '0;
            err_beat_q  <= '0;
            fail_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_cnt_q  <= fail_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            s1_valid_q  <= accept;
            err_valid_q <= s1_valid_q;
            if (accept) begin
                s1_data_q <= dut_data;
                s1_beat_q <= acc_q;
                acc_q     <= acc_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (s1_valid_q) begin
                err_mask_q <= lane_mask;
                err_beat_q <= s1_beat_q;
            end
            if (dut_valid && (state_q != StRun)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        err_valid     = err_valid_q;
        err_lane_mask = err_mask_q;
        err_beat      = err_beat_q;
        fail_cnt      = fail_cnt_q;
        beat_cnt      = beat_cnt_q[AW-1:0];
        busy          = (state_q == StRun);
        pass          = (state_q == StPass);
        fail          = (state_q == StFail);
        overrun       = overrun_q;
    end

endmodule

// File: tb/tb_fas_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_fas_stream_checker
// Self-checking bench: a reference model of the checker's rules is updated
// every cycle and compared with the default build; table vectors and
// directed sequences cover the tolerance boundaries, wrap, limit, reset and
// a 4-lane real-only build.
// ---------------------------------------------------------------------------
module tb_fas_stream_checker;

    localparam int unsigned W          = 16;
    localparam int unsigned LANES      = 16;
    localparam int unsigned COMPLEX    = 1;
    localparam int unsigned TOL        = 3;
    localparam int unsigned N_BEATS    = 64;
    localparam int unsigned FAIL_LIMIT = 48;
    localparam int unsigned AW         = 10;
    localparam int unsigned FPL        = COMPLEX + 1;
    localparam int unsigned NF         = LANES * FPL;
    localparam int unsigned LW         = NF * W;
    localparam int unsigned DEPTH      = 1 << AW;
    localparam int unsigned LW4        = 4 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic             rst = 1'b1;
    logic             dut_valid = 1'b0;
    logic [LW-1:0]    dut_data = '0;
    logic             gold_rd;
    logic [AW-1:0]    gold_addr;
    logic [LW-1:0]    gold_data = '0;
    logic             err_valid;
    logic [LANES-1:0] err_lane_mask;
    logic [AW-1:0]    err_beat;
    logic [7:0]       fail_cnt;
    logic [AW-1:0]    beat_cnt;
    logic             busy, pass, fail, overrun;

    logic [LW-1:0]    gold_mem [0:DEPTH-1];
    always @(posedge clk) if (gold_rd) gold_data <= gold_mem[gold_addr];

    fas_stream_checker #(
        .W(W), .LANES(LANES), .COMPLEX(COMPLEX), .TOL(TOL),
        .N_BEATS(N_BEATS), .FAIL_LIMIT(FAIL_LIMIT), .AW(AW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .dut_valid     (dut_valid),
        .dut_data      (dut_data),
        .gold_rd       (gold_rd),
        .gold_addr     (gold_addr),
        .gold_data     (gold_data),
        .err_valid     (err_valid),
        .err_lane_mask (err_lane_mask),
        .err_beat      (err_beat),
        .fail_cnt      (fail_cnt),
        .beat_cnt      (beat_cnt),
        .busy          (busy),
        .pass          (pass),
        .fail          (fail),
        .overrun       (overrun)
    );

    // 4-lane real-only build
    logic            rst4 = 1'b1;
    logic            v4 = 1'b0;
    logic [LW4-1:0]  data4 = '0;
    logic            rd4;
    logic [AW-1:0]   addr4;
    logic [LW4-1:0]  gold4_data = '0;
    logic            ev4;
    logic [3:0]      mask4;
    logic [AW-1:0]   beat4;
    logic [7:0]      fc4;
    logic [AW-1:0]   bc4;
    logic            busy4, pass4, fail4, ovr4;
    logic [LW4-1:0]  gold4_mem [0:3];
    always @(posedge clk) if (rd4) gold4_data <= gold4_mem[addr4[1:0]];

    fas_stream_checker #(
        .W(W), .LANES(4), .COMPLEX(0), .TOL(TOL),
        .N_BEATS(N_BEATS), .FAIL_LIMIT(FAIL_LIMIT), .AW(AW)
    ) u_dut4 (
        .clk           (clk),
        .rst           (rst4),
        .dut_valid     (v4),
        .dut_data      (data4),
        .gold_rd       (rd4),
        .gold_addr     (addr4),
        .gold_data     (gold4_data),
        .err_valid     (ev4),
        .err_lane_mask (mask4),
        .err_beat      (beat4),
        .fail_cnt      (fc4),
        .beat_cnt      (bc4),
        .busy          (busy4),
        .pass          (pass4),
        .fail          (fail4),
        .overrun       (ovr4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rules
    function automatic bit field_ok(input logic [W-1:0] g, input logic [W-1:0] d);
        int unsigned gu, du, dd;
        gu = g;
        du = d;
        dd = (du + (1 << W) - gu) % (1 << W);
        return (dd <= TOL) || (dd >= (1 << W) - TOL);
    endfunction

    function automatic logic [LANES-1:0] ref_mask(input logic [LW-1:0] dv,
                                                  input logic [LW-1:0] gv);
        logic [LANES-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++)
            for (int f = 0; f < FPL; f++)
                if (!field_ok(gv[(l*FPL+f)*W +: W], dv[(l*FPL+f)*W +: W])) m[l] = 1'b1;
        return m;
    endfunction

    function automatic logic [LW-1:0] rnd_word();
        logic [LW-1:0] w;
        for (int i = 0; i < LW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [LW-1:0] set_field(input logic [LW-1:0] w, input int fidx,
                                                input logic [W-1:0] v);
        logic [LW-1:0] r;
        r = w;
        r[fidx*W +: W] = v;
        return r;
    endfunction

    // pct: percent of fields pushed clearly outside the tolerance window
    function automatic logic [LW-1:0] perturb(input logic [LW-1:0] g, input int pct);
        logic [LW-1:0] r;
        int dv;
        r = g;
        for (int f = 0; f < NF; f++) begin
            if (int'($urandom_range(99)) < pct) begin
                dv = int'($urandom_range(4, 40));
                if ($urandom_range(1) == 1) dv = -dv;
            end else begin
                dv = int'($urandom_range(0, 2 * TOL)) - int'(TOL);
            end
            r[f*W +: W] = g[f*W +: W] + dv[W-1:0];
        end
        return r;
    endfunction

    // Model state
    typedef struct {
        int               cyc;
        int               idx;
        logic [LANES-1:0] mask;
    } pend_t;

    pend_t            pq[$];
    int               cyc = 0;
    int               m_state = 0;  // 0 run, 1 pass, 2 fail
    int               m_fail = 0;
    int               m_beats = 0;
    int               m_acc = 0;
    bit               m_over = 1'b0;
    bit               e_ev = 1'b0;
    logic [LANES-1:0] e_mask = '0;
    int               e_beat = 0;
    bit               last_rd;
    logic [AW-1:0]    last_addr;

    // One clock cycle: drive inputs, check stage-0 outputs, clock, update the
    // model and compare all registered outputs.
    task automatic step(input bit r, input bit v, input logic [LW-1:0] d,
                        input logic [LW-1:0] g);
        bit    acc;
        bit    full;
        int    st0;
        pend_t p;
        rst       = r;
        dut_valid = v;
        dut_data  = d;
        if (v) gold_mem[m_acc % DEPTH] = g;
        acc = !r && v && (m_state == 0);
        #1;
        chk("gold_rd", gold_rd, acc);
        if (acc) chk("gold_addr", gold_addr, m_acc % DEPTH);
        last_rd   = gold_rd;
        last_addr = gold_addr;
        @(posedge clk);
        #1;
        full = 1'b0;
        if (r) begin
            m_state = 0; m_fail = 0; m_beats = 0; m_acc = 0; m_over = 1'b0;
            e_ev = 1'b0; e_mask = '0; e_beat = 0;
            pq.delete();
            full = 1'b1;
        end else begin
            st0  = m_state;
            e_ev = 1'b0;
            if (pq.size() > 0 && pq[0].cyc == cyc - 1) begin
                p      = pq.pop_front();
                e_ev   = 1'b1;
                e_mask = p.mask;
                e_beat = p.idx;
                if (st0 == 0) begin
                    m_beats++;
                    m_fail = m_fail + $countones(p.mask);
                    if (m_fail > 255) m_fail = 255;
                    if (m_fail >= FAIL_LIMIT) m_state = 2;
                    else if (m_beats == N_BEATS) m_state = (m_fail == 0) ? 1 : 2;
                end
            end
            if (v && st0 != 0) m_over = 1'b1;
            if (acc) begin
                p.cyc  = cyc;
                p.idx  = m_acc;
                p.mask = ref_mask(d, g);
                pq.push_back(p);
                m_acc++;
            end
        end
        cyc++;
        chk("err_valid", err_valid, e_ev);
        if (e_ev || full) begin
            chk("err_lane_mask", err_lane_mask, e_mask);
            chk("err_beat", err_beat, e_beat % DEPTH);
        end
        chk("fail_cnt", fail_cnt, m_fail);
        chk("beat_cnt", beat_cnt, m_beats % DEPTH);
        chk("busy", busy, m_state == 0);
        chk("pass", pass, m_state == 1);
        chk("fail", fail, m_state == 2);
        chk("overrun", overrun, m_over);
    endtask

    typedef struct {
        logic [W-1:0] gf;
        logic [W-1:0] df;
        bit           ok;
    } vec_t;

    vec_t vt [10];
    int   bad_lanes [4] = '{0, 5, 9, 15};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] g, d;
        logic [W-1:0]  fv;
        int            nz, lane, fidx, pct;
        bit            r, v;

        vt[0] = '{16'h0100, 16'h0103, 1'b1};
        vt[1] = '{16'h0100, 16'h0104, 1'b0};
        vt[2] = '{16'hFFFE, 16'h0001, 1'b1};
        vt[3] = '{16'hFFFC, 16'h0000, 1'b0};
        vt[4] = '{16'h0000, 16'hFFFF, 1'b1};
        vt[5] = '{16'h0005, 16'h0002, 1'b1};
        vt[6] = '{16'h0005, 16'h0001, 1'b0};
        vt[7] = '{16'h8000, 16'h7FFC, 1'b0};
        vt[8] = '{16'h8000, 16'h7FFD, 1'b1};
        vt[9] = '{16'h1234, 16'h1234, 1'b1};

        #1;
        // Reset state
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        chk("rst_busy", busy, 1);
        chk("rst_pass", pass, 0);

        // Table vectors: one edited field per beat, real and imag alternately
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            lane = i % LANES;
            fidx = lane * FPL + ((i % 2 == 0) ? FPL - 1 : 0);
            g = set_field(rnd_word(), fidx, vt[i].gf);
            d = set_field(g, fidx, vt[i].df);
            step(1'b0, 1'b1, d, g);
            step(1'b0, 1'b0, '0, '0);
            chk($sformatf("tbl_valid[%0d]", i), err_valid, 1);
            chk($sformatf("tbl_mask[%0d]", i), err_lane_mask,
                vt[i].ok ? 64'd0 : (64'd1 << lane));
        end

        // 64 clean beats back to back
        step(1'b1, 1'b0, '0, '0);
        nz = 0;
        for (int b = 0; b < 64; b++) begin
            g = rnd_word();
            step(1'b0, 1'b1, g, g);
            if (err_valid && err_lane_mask != 0) nz++;
        end
        step(1'b0, 1'b0, '0, '0);
        if (err_valid && err_lane_mask != 0) nz++;
        chk("clean_pass_t2", pass, 1);
        chk("clean_fail_cnt", fail_cnt, 0);
        chk("clean_nz_masks", nz, 0);
        chk("clean_beat_cnt", beat_cnt, 64);
        step(1'b0, 1'b1, rnd_word(), '0);
        chk("pass_gold_rd", last_rd, 0);
        chk("pass_overrun", overrun, 1);
        step(1'b0, 1'b0, '0, '0);
        chk("pass_no_err", err_valid, 0);

        // Beat 5 lane 3 real: +3 passes, +4 fails
        for (int run = 0; run < 2; run++) begin
            step(1'b1, 1'b0, '0, '0);
            for (int b = 0; b < 6; b++) begin
                g = rnd_word();
                d = g;
                if (b == 5) begin
                    g = set_field(g, 3 * FPL + FPL - 1, 16'h0100);
                    d = set_field(g, 3 * FPL + FPL - 1, (run == 0) ? 16'h0103 : 16'h0104);
                end
                step(1'b0, 1'b1, d, g);
            end
            step(1'b0, 1'b0, '0, '0);
            chk("b5_valid", err_valid, 1);
            chk("b5_beat", err_beat, 5);
            chk("b5_mask", err_lane_mask, (run == 0) ? 16'h0000 : 16'h0008);
            chk("b5_fail_cnt", fail_cnt, run);
        end

        // Four failing lanes per beat reach the limit on beat 11
        step(1'b1, 1'b0, '0, '0);
        for (int b = 0; b < 12; b++) begin
            g = rnd_word();
            d = g;
            for (int k = 0; k < 4; k++) begin
                fidx = bad_lanes[k] * FPL + FPL - 1;
                fv = g[fidx*W +: W] + 16'd10;
                d = set_field(d, fidx, fv);
            end
            step(1'b0, 1'b1, d, g);
            if (b == 11) chk("lim_not_early", fail, 0);
        end
        step(1'b0, 1'b0, '0, '0);
        chk("lim_fail", fail, 1);
        chk("lim_busy", busy, 0);
        chk("lim_fail_cnt", fail_cnt, 48);
        chk("lim_err_beat", err_beat, 11);
        step(1'b0, 1'b1, rnd_word(), '0);
        chk("lim_gold_rd", last_rd, 0);
        chk("lim_overrun", overrun, 1);

        // Reset at beat 30 (with a beat present), then a fresh full run
        step(1'b1, 1'b0, '0, '0);
        for (int b = 0; b < 30; b++) begin
            g = rnd_word();
            step(1'b0, 1'b1, g, g);
        end
        g = rnd_word();
        step(1'b1, 1'b1, g, g);
        chk("mid_rst_gold_rd", last_rd, 0);
        chk("mid_rst_err_valid", err_valid, 0);
        chk("mid_rst_mask", err_lane_mask, 0);
        chk("mid_rst_beat_cnt", beat_cnt, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_fail", fail, 0);
        for (int b = 0; b < 64; b++) begin
            g = rnd_word();
            step(1'b0, 1'b1, g, g);
            if (b == 0) chk("restart_addr", last_addr, 0);
        end
        step(1'b0, 1'b0, '0, '0);
        chk("restart_pass", pass, 1);

        // Randomized runs against the model
        for (int run = 0; run < 6; run++) begin
            pct = (run % 3 == 0) ? 0 : ((run % 3 == 1) ? 1 : 4);
            step(1'b1, 1'b0, '0, '0);
            for (int c = 0; c < 160; c++) begin
                r = ($urandom_range(199) == 0);
                v = ($urandom_range(99) < 75);
                g = rnd_word();
                d = perturb(g, pct);
                step(r, v, d, g);
            end
        end
        rst = 1'b0;
        dut_valid = 1'b0;

        // 4-lane real-only build: 4-LSB error on lane 0 is caught
        gold4_mem[0] = 64'h1111_2222_3333_4444;
        gold4_mem[1] = 64'h0000_FFFF_8000_0010;
        gold4_mem[2] = 64'h5555_6666_7777_8888;
        gold4_mem[3] = '0;
        rst4 = 1'b1;
        @(posedge clk); #1;
        chk("c0_rst_busy", busy4, 1);
        rst4 = 1'b0;
        v4 = 1'b1;
        data4 = 64'h1111_2222_3333_4448;
        @(posedge clk); #1;
        data4 = 64'h0000_FFFF_8000_0013;
        @(posedge clk); #1;
        chk("c0_b0_valid", ev4, 1);
        chk("c0_b0_mask", mask4, 4'h1);
        chk("c0_b0_beat", beat4, 0);
        data4 = 64'h5551_6666_7777_8888;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("c0_b1_mask", mask4, 4'h0);
        chk("c0_b1_beat", beat4, 1);
        @(posedge clk); #1;
        chk("c0_b2_mask", mask4, 4'h8);
        chk("c0_b2_beat", beat4, 2);
        chk("c0_fail_cnt", fc4, 2);
        chk("c0_beat_cnt", bc4, 3);
        chk("c0_state", {busy4, pass4, fail4, ovr4, rd4}, 5'b10000);
        chk("c0_addr", addr4, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
